bitmap_ram_arbiter: RTL
=======================

Name: bitmap_ram_arbiter

Overview:
- Arbiter and sequencer for the single-port 32K x 8 bitmap DRAM.
- Shares the RAM between three requesters: video refresh fetch (highest priority), CPU bus access incl. bitmode nibble writes, and an optional hardware screen-clear engine (lowest priority).
- Sits between the address decoder / auto-increment logic, the pixel shifter and the RAM macro.
- Grants one RAM access per clk cycle; drives registered RAM port signals.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 8, RAM data width; must be even (two nibble lanes).
- CLR_LAST, 15'h7FFF, last address written by the clear engine.

Ports:
- clk  in  1  system clock (10 MHz).
- reset_n  in  1  synchronous active-low reset.
- vid_req  in  1  one-cycle video fetch request.
- vid_addr  in  ADDR_W  video fetch address.
- vid_valid  out  1  one-cycle strobe; vid_data valid.
- vid_data  out  DATA_W  fetched video byte.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address (DRBA).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_nib  in  2  nibble write enables [1]=hi, [0]=lo; 2'b11 = byte write.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack on reads.
- clr_start  in  1  start clear (macro only).
- clr_value  in  DATA_W  clear fill byte (macro only).
- clr_busy  out  1  clear in progress.
- stall_cnt  out  8  saturating count of CPU grant cycles lost to video.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_we  out  2  per-nibble write enables, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM read data, one cycle after address.

Behaviour:
- Reset (reset_n low at clk edge):
  - All outputs 0; stall_cnt=0; clr_busy=0; state IDLE.
  - Any in-flight read is discarded; no vid_valid or cpu_ack follows reset.
- Arbitration each edge k: priority vid_req > pending CPU > clear.
  - Winner's address, write enables and data are registered onto ram_* for cycle k+1.
  - With no winner, ram_we=0 and ram_addr holds its previous value.
- States:
  - IDLE: no CPU access outstanding.
  - CPU_ISSUED: the CPU access is on the RAM port.
  - CPU_DONE: ack cycle. Always returns to IDLE.
  - Video and clear accesses are pipelined tokens and do not use the FSM.
- Video path:
  - vid_req at edge k is always granted; video may issue on consecutive cycles.
  - ram_rdata is captured at edge k+2; vid_valid is high for the cycle after edge k+2, with vid_data.
  - Fixed latency of 2 edges; never dropped.
- CPU path:
  - cpu_req high in IDLE with no vid_req: grant at edge k, CPU_ISSUED.
  - Write: ram_we={cpu_nib[1],cpu_nib[0]}, ram_wdata=cpu_wdata; cpu_ack high the cycle after edge k+1.
  - Read: ram_we=0; cpu_rdata captured at edge k+2; cpu_ack pulses in the same cycle as the capture.
  - The requester drops cpu_req in the ack cycle. The arbiter ignores cpu_req during CPU_ISSUED/CPU_DONE, so there is no double grant.
  - Every edge where cpu_req is high in IDLE and vid_req wins increments stall_cnt, saturating at 8'hFF. stall_cnt clears only on reset.
- Simultaneous vid_req and cpu_req: video at edge k; CPU at the first following edge without vid_req.
- cpu_nib=2'b00 on a write: no RAM write, but ack is still returned at normal timing.
- Address inputs wrap naturally within ADDR_W; no range checking.

Optional Feature:
- Macro: BITMAP_CLEAR_ENGINE_EN.
- With the macro:
  - clr_start at an edge with clr_busy=0 latches clr_value, sets clr_busy and zeroes the clear pointer.
  - The engine writes clr_value (ram_we=2'b11) at the pointer on every edge with no video or CPU grant, then increments the pointer.
  - After writing CLR_LAST, clr_busy drops on the next edge.
  - clr_start while busy is ignored.
  - Reset mid-clear aborts it: clr_busy=0, remaining addresses unwritten.
- Without the macro: clr_busy is tied 0, clr_start/clr_value are ignored, and no clear logic is synthesised.

Test Plan:
- Reset released, no requests -> all outputs 0 for 10 cycles; ram_we=0.
- cpu write addr 15'h1234, data 8'hA5, nib 2'b11 -> ram_we=2'b11 and addr 15'h1234 one cycle after grant; cpu_ack next cycle; later read returns 8'hA5 with ack 2 edges after grant.
- Nibble write 8'h3C, nib 2'b01 over 8'hA5 -> read back 8'hAC.
- vid_req and cpu_req in the same cycle, then vid_req for 3 more cycles -> 4 video accesses first, CPU granted on the 5th edge, stall_cnt=4; vid_valid exactly 2 edges after each request.
- 300 consecutive video cycles while CPU waits -> stall_cnt saturates at 8'hFF; CPU served once video stops.
- With BITMAP_CLEAR_ENGINE_EN: clr_start, value 8'h00, with interleaved CPU writes -> every address 0..7FFF written 8'h00 exactly once; CPU writes retain ack timing; clr_busy falls after 7FFF. Reset at pointer 0x100 -> clr_busy=0 and address 0x100 unchanged.

Source files
------------

// File: rtl/bitmap_ram_arbiter.sv
// bitmap_ram_arbiter: owns the single-port bitmap DRAM and grants one access
// per clk cycle. Video fetch has top priority, then the CPU, then the optional
// screen-clear engine (define BITMAP_CLEAR_ENGINE_EN to build it).
// DATA_W must be even: ram_we[1] enables the upper nibble lane and ram_we[0]
// enables the lower one.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no CPU access outstanding; cpu_req may be granted
// CPU_ISSUED | CPU access on the RAM port (reads stay one extra cycle)
// CPU_DONE   | cpu_ack cycle; always returns to IDLE
module bitmap_ram_arbiter #(
  parameter int                ADDR_W   = 15,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(15'h7FFF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_nib,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [7:0]        stall_cnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_ISSUED, CPU_DONE} state_t;

  state_t state;
  logic   rd_wait;   // read still waiting for RAM data
  logic   cpu_rd;    // outstanding CPU access is a read
  logic   vid_p1;    // video token: address on RAM port
  logic   vid_p2;    // video token: data on ram_rdata
  logic   cpu_grant;

  // CPU may only win in IDLE and only when video is not asking this cycle
  assign cpu_grant = (state == IDLE) && cpu_req && !vid_req;

`ifdef BITMAP_CLEAR_ENGINE_EN
  logic              clr_busy_r;
  logic              clr_fin;   // CLR_LAST issued, busy drops next edge
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] clr_val;
  logic              clr_grant;

  // clear engine takes the port only when nobody else wants it
  assign clr_grant = clr_busy_r && !clr_fin && !vid_req && !cpu_grant;
  assign clr_busy  = clr_busy_r;
`else
  logic unused_clr;

  // clear inputs have no function in this build
  assign unused_clr = ^{clr_start, clr_value};
  assign clr_busy   = 1'b0;
`endif

  // arbitration, RAM port registers, video pipeline, CPU FSM and clear engine
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_wait   <= 1'b0;
      cpu_rd    <= 1'b0;
      vid_p1    <= 1'b0;
      vid_p2    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      stall_cnt <= '0;
      ram_addr  <= '0;
      ram_we    <= 2'b00;
      ram_wdata <= '0;
`ifdef BITMAP_CLEAR_ENGINE_EN
      clr_busy_r <= 1'b0;
      clr_fin    <= 1'b0;
      clr_ptr    <= '0;
      clr_val    <= '0;
`endif
    end else begin
      ram_we <= 2'b00;
      if (vid_req) begin
        ram_addr <= vid_addr;
      end else if (cpu_grant) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_we    <= cpu_we ? cpu_nib : 2'b00;
      end
`ifdef BITMAP_CLEAR_ENGINE_EN
      else if (clr_grant) begin
        ram_addr  <= clr_ptr;
        ram_wdata <= clr_val;
        ram_we    <= 2'b11;
      end
`endif

      vid_p1    <= vid_req;
      vid_p2    <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2) vid_data <= ram_rdata;

      if ((state == IDLE) && cpu_req && vid_req && (stall_cnt != 8'hFF))
        stall_cnt <= stall_cnt + 8'd1;

      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_grant) begin
            state   <= CPU_ISSUED;
            rd_wait <= !cpu_we;
            cpu_rd  <= !cpu_we;
          end
        end
        CPU_ISSUED: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            state   <= CPU_DONE;
            cpu_ack <= 1'b1;
            if (cpu_rd) cpu_rdata <= ram_rdata;
          end
        end
        CPU_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase

`ifdef BITMAP_CLEAR_ENGINE_EN
      if (clr_busy_r) begin
        if (clr_fin) begin
          clr_busy_r <= 1'b0;
          clr_fin    <= 1'b0;
        end else if (clr_grant) begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == CLR_LAST) clr_fin <= 1'b1;
        end
      end else if (clr_start) begin
        clr_busy_r <= 1'b1;
        clr_fin    <= 1'b0;
        clr_ptr    <= '0;
        clr_val    <= clr_value;
      end
`endif
    end
  end

endmodule
